// File: rtl/teller_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// teller_dispatcher_pkg
// Shared definitions for the bank teller dispatcher: teller count, default
// ticket width, dispatcher FSM state encoding and small bit helpers used by
// both the top level and the round-robin arbiter.
// ---------------------------------------------------------------------------
package teller_dispatcher_pkg;

    localparam int NUM_TELLERS      = 3;
    localparam int TICKET_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } disp_state_e;

    // Number of set bits in a three-teller mask.
    function automatic logic [1:0] popcount3(input logic [2:0] v);
        popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    // Index of the set bit in a one-hot three-teller mask (0 when empty).
    function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/teller_dispatcher_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter3
// Purely combinational round-robin arbiter for three tellers. The search
// starts at the teller following the one granted last and wraps around.
// Ports:
//   req_i   [2:0]  tellers currently requesting a customer
//   last_i  [1:0]  index of the teller granted most recently (0..2)
//   win_o   [2:0]  one-hot winner, all zero when req_i is zero
// ---------------------------------------------------------------------------
module rr_arbiter3
    import teller_dispatcher_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [2:0] win_o
);

    always_comb begin
        win_o = 3'b000;
        case (last_i)
            2'd0: begin
                if      (req_i[1]) win_o = 3'b010;
                else if (req_i[2]) win_o = 3'b100;
                else if (req_i[0]) win_o = 3'b001;
            end
            2'd1: begin
                if      (req_i[2]) win_o = 3'b100;
                else if (req_i[0]) win_o = 3'b001;
                else if (req_i[1]) win_o = 3'b010;
            end
            default: begin
                if      (req_i[0]) win_o = 3'b001;
                else if (req_i[1]) win_o = 3'b010;
                else if (req_i[2]) win_o = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/teller_dispatcher.sv
// ---------------------------------------------------------------------------
// teller_dispatcher
// Hands the customer at the head of the ticket queue to the next ready teller.
// Sits between the push-button FSM / queue counter and the wait-time ROM: it
// drives the counter's Down input (pop) and the per-teller activity levels.
// Ports:
//   clk             system clock, all state on the rising edge
//   rst             asynchronous active-low reset
//   push            one-cycle pulse, a customer joined the queue
//   pcount [2:0]    current queue occupancy from the queue counter, 0..7
//   teller_req[2:0] one-cycle pulses, teller t ready for a new customer
//   pop             one-cycle pulse to the queue counter Down input
//   grant [2:0]     one-hot teller served, coincident with pop
//   busy [2:0]      teller t has a customer and has not asked for another
//   serving_ticket  ticket last given to each teller, teller t at [t*W +: W]
//   next_ticket     ticket number of the queue head
//   active_tellers  number of busy tellers, 0..3
// ---------------------------------------------------------------------------
module teller_dispatcher
    import teller_dispatcher_pkg::*;
#(
    parameter int TICKET_W   = TICKET_W_DEFAULT,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [2:0]            pcount,
    input  logic [2:0]            teller_req,
    output logic                  pop,
    output logic [2:0]            grant,
    output logic [2:0]            busy,
    output logic [3*TICKET_W-1:0] serving_ticket,
    output logic [TICKET_W-1:0]   next_ticket,
    output logic [1:0]            active_tellers
);

    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    disp_state_e state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d;

    logic [2:0] pending_q, pending_d;
    logic [2:0] busy_q, busy_d;
    logic [2:0] grant_q, grant_d;
    logic       pop_q, pop_d;
    logic [1:0] last_q, last_d;
    logic [1:0] active_q, active_d;
    logic [TICKET_W-1:0]   head_q, head_d;
    logic [TICKET_W-1:0]   tail_q, tail_d;
    logic [3*TICKET_W-1:0] serv_q, serv_d;

    logic [2:0] req_eff;
    logic [2:0] win;
    logic       take;

    // A request arriving on the deciding edge counts immediately, which gives
    // the one-cycle request-to-pop latency out of IDLE.
    assign req_eff = pending_q | teller_req;

    rr_arbiter3 u_arb (
        .req_i  (req_eff),
        .last_i (last_q),
        .win_o  (win)
    );

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((req_eff != 3'b000) && (pcount != 3'd0)) begin
                    take    = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // ---------------- Datapath: tickets, pending, busy ----------------
    // All effects of a grant are registered on the edge that enters GRANT,
    // so pop, grant, busy and serving_ticket become visible together.
    always_comb begin
        pending_d = pending_q | teller_req;
        busy_d    = busy_q & ~teller_req;
        serv_d    = serv_q;
        head_d    = head_q;
        tail_d    = tail_q;
        last_d    = last_q;
        pop_d     = take;
        grant_d   = take ? win : 3'b000;

        // A full queue only accepts a new customer while one is leaving.
        if (push && ((pcount != 3'd7) || pop_q)) begin
            tail_d = tail_q + 1'b1;
        end

        if (take) begin
            pending_d = pending_d & ~win;
            busy_d    = busy_d | win;
            head_d    = head_q + 1'b1;
            last_d    = onehot3_to_idx(win);
            for (int t = 0; t < NUM_TELLERS; t++) begin
                if (win[t]) serv_d[t*TICKET_W +: TICKET_W] = head_q;
            end
        end

        active_d = popcount3(busy_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 3'b000;
            busy_q    <= 3'b000;
            grant_q   <= 3'b000;
            pop_q     <= 1'b0;
            last_q    <= 2'd2;      // "last" = teller three, so search starts at teller one
            active_q  <= 2'd0;
            head_q    <= '0;
            tail_q    <= '0;
            serv_q    <= '0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            pop_q     <= pop_d;
            last_q    <= last_d;
            active_q  <= active_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            serv_q    <= serv_d;
        end
    end

    assign pop            = pop_q;
    assign grant          = grant_q;
    assign busy           = busy_q;
    assign serving_ticket = serv_q;
    assign next_ticket    = head_q;
    assign active_tellers = active_q;

endmodule

// File: tb/tb_teller_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_teller_dispatcher
// Self-checking bench for teller_dispatcher: directed scenarios plus a
// randomized run, all compared against a behavioural model of the dispatcher.
// ---------------------------------------------------------------------------
module tb_teller_dispatcher;

    localparam int TW = 4;
    localparam int G  = 2;
    localparam int TMOD = 1 << TW;

    logic            clk = 1'b0;
    logic            rst;
    logic            push;
    logic [2:0]      pcount;
    logic [2:0]      teller_req;
    logic            pop;
    logic [2:0]      grant;
    logic [2:0]      busy;
    logic [3*TW-1:0] serving_ticket;
    logic [TW-1:0]   next_ticket;
    logic [1:0]      active_tellers;

    always #5 clk = ~clk;

    teller_dispatcher #(.TICKET_W(TW), .GAP_CYCLES(G)) dut (
        .clk            (clk),
        .rst            (rst),
        .push           (push),
        .pcount         (pcount),
        .teller_req     (teller_req),
        .pop            (pop),
        .grant          (grant),
        .busy           (busy),
        .serving_ticket (serving_ticket),
        .next_ticket    (next_ticket),
        .active_tellers (active_tellers)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model state
    logic [2:0] m_pend, m_busy, m_grant;
    logic       m_pop;
    int         m_last, m_cool, m_head, m_tail;
    int         m_serv [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        m_pend = 3'b000; m_busy = 3'b000; m_grant = 3'b000; m_pop = 1'b0;
        m_last = 2; m_cool = 0; m_head = 0; m_tail = 0;
        for (int t = 0; t < 3; t++) m_serv[t] = 0;
    endtask

    // One clock edge of the dispatcher, from the rules in plain terms.
    task automatic mstep(input logic p, input logic [2:0] r, input int pc);
        logic [2:0] req;
        int w;
        if (p && (pc != 7 || m_pop)) m_tail = (m_tail + 1) % TMOD;
        req    = m_pend | r;
        m_busy = m_busy & ~r;
        m_grant = 3'b000;
        if (m_cool == 0 && req != 3'b000 && pc != 0) begin
            w = -1;
            for (int k = 1; k <= 3; k++)
                if (w < 0 && req[(m_last + k) % 3]) w = (m_last + k) % 3;
            m_pop     = 1'b1;
            m_grant[w] = 1'b1;
            m_busy[w] = 1'b1;
            m_serv[w] = m_head;
            m_head    = (m_head + 1) % TMOD;
            req[w]    = 1'b0;
            m_last    = w;
            m_cool    = G + 1;   // the grant cycle plus the gap
        end else begin
            m_pop = 1'b0;
            if (m_cool > 0) m_cool--;
        end
        m_pend = req;
    endtask

    task automatic cmp_all();
        chk("pop",    32'(pop),            32'(m_pop));
        chk("grant",  32'(grant),          32'(m_grant));
        chk("busy",   32'(busy),           32'(m_busy));
        chk("next",   32'(next_ticket),    32'(m_head));
        chk("active", 32'(active_tellers), 32'($countones(m_busy)));
        chk("tail",   32'(dut.tail_q),     32'(m_tail));
        for (int t = 0; t < 3; t++)
            chk($sformatf("serv%0d", t), 32'(serving_ticket[t*TW +: TW]), 32'(m_serv[t]));
    endtask

    task automatic cyc(input logic p, input logic [2:0] r, input logic [2:0] pc);
        push = p; teller_req = r; pcount = pc;
        @(posedge clk);
        mstep(p, r, int'(pc));
        #1;
        cmp_all();
        push = 1'b0; teller_req = 3'b000;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pop"},    32'(pop),            32'd0);
        chk({tag, "_grant"},  32'(grant),          32'd0);
        chk({tag, "_busy"},   32'(busy),           32'd0);
        chk({tag, "_serv"},   32'(serving_ticket), 32'd0);
        chk({tag, "_next"},   32'(next_ticket),    32'd0);
        chk({tag, "_active"}, 32'(active_tellers), 32'd0);
    endtask

    // Assert reset between edges, check outputs clear at once, release on negedge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b0;
        mreset();
        #1;
        chk_zero_outputs(tag);
        chk({tag, "_pend"}, 32'(dut.pending_q), 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int  q;
        logic p, pb;
        logic [2:0] r;

        rst = 1'b0; push = 1'b0; teller_req = 3'b000; pcount = 3'd0;
        mreset();
        #2;
        chk_zero_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        // First request with a non-empty queue is served on the next edge.
        cyc(1'b0, 3'b001, 3'd3);
        chk("first_pop",    32'(pop),                     32'd1);
        chk("first_grant",  32'(grant),                   32'b001);
        chk("first_serv0",  32'(serving_ticket[TW-1:0]),  32'd0);
        chk("first_busy",   32'(busy),                    32'b001);
        chk("first_active", 32'(active_tellers),          32'd1);
        repeat (4) cyc(1'b0, 3'b000, 3'd2);

        // Requests wait on an empty queue; a push alone cannot grant that edge.
        do_reset("rst36");
        cyc(1'b0, 3'b111, 3'd0);
        cyc(1'b1, 3'b000, 3'd0);
        chk("empty_nopop", 32'(pop), 32'd0);
        cyc(1'b0, 3'b000, 3'd1);
        chk("one_grant",   32'(grant),          32'b001);
        chk("pend_left",   32'(dut.pending_q),  32'b110);
        repeat (8) cyc(1'b0, 3'b000, 3'd0);
        chk("still_pend",  32'(dut.pending_q),  32'b110);

        // Round-robin order with all three pending, G+1 idle cycles apart.
        do_reset("rst37");
        cyc(1'b0, 3'b111, 3'd5);
        chk("rr_g0", 32'(grant), 32'b001);
        for (int i = 1; i <= 9; i++) begin
            cyc(1'b0, 3'b000, 3'd5);
            if (i == G + 2)     chk("rr_g1", 32'(grant), 32'b010);
            if (i == 2 * G + 4) chk("rr_g2", 32'(grant), 32'b100);
        end

        // Full queue: push accepted only while a pop is in flight.
        do_reset("rst39");
        cyc(1'b0, 3'b001, 3'd7);
        cyc(1'b1, 3'b000, 3'd7);
        chk("full_pushpop_tail", 32'(dut.tail_q),   32'd1);
        chk("full_pushpop_head", 32'(next_ticket),  32'd1);
        cyc(1'b1, 3'b000, 3'd7);
        chk("full_push_tail",    32'(dut.tail_q),   32'd1);

        // Ticket wrap over 17 grants.
        do_reset("rst38");
        for (int n = 0; n < 17; n++) begin
            cyc(1'b1, 3'b001, 3'd3);
            chk("wrap_serv", 32'(serving_ticket[TW-1:0]), 32'(n % TMOD));
            repeat (G + 1) cyc(1'b0, 3'b000, 3'd3);
        end
        chk("wrap_head", 32'(next_ticket), 32'd1);

        // Reset during the gap: everything clears, no pop until a new request.
        do_reset("rst40a");
        cyc(1'b0, 3'b011, 3'd4);
        cyc(1'b0, 3'b000, 3'd4);
        do_reset("gap_rst");
        repeat (6) cyc(1'b0, 3'b000, 3'd4);
        cyc(1'b0, 3'b100, 3'd4);
        chk("after_rst_grant", 32'(grant), 32'b100);

        // Randomized traffic with a queue counter model driving pcount.
        do_reset("rnd");
        q = 0;
        for (int i = 0; i < 400; i++) begin
            p  = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            pb = m_pop;
            cyc(p, r, 3'(q));
            q = q + ((p && (q != 7 || pb)) ? 1 : 0) - (pb ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/teller_dispatcher.md
TELLER_DISPATCHER -- requirements
Module: teller_dispatcher

Interface
REQ-001 SHALL have parameter TICKET_W, default 4, width of customer ticket numbers.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, idle cycles forced after each grant so the queue counter and wait-time ROM settle.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push  input  1  one-cycle pulse: customer joined the queue (debounced FSM Up).
REQ-006 SHALL have port pcount  input  3  current queue occupancy, 0..7.
REQ-007 SHALL have port teller_req  input  3  one-cycle pulses, bit0/1/2 = teller one/two/three ready for next customer.
REQ-008 SHALL have port pop  output  1  one-cycle pulse to queue counter Down.
REQ-009 SHALL have port grant  output  3  one-hot one-cycle pulse naming the teller served, coincident with pop.
REQ-010 SHALL have port busy  output  3  per-teller level: customer assigned, no new request yet.
REQ-011 SHALL have port serving_ticket  output  3xTICKET_W  ticket last assigned to each teller.
REQ-012 SHALL have port next_ticket  output  TICKET_W  ticket of the queue head.
REQ-013 SHALL have port active_tellers  output  2  count of busy tellers, 0..3.

Function
REQ-014 SHALL latch each teller_req bit into pending[2:0]; bit cleared only when that teller is granted.
REQ-015 SHALL clear busy[t] on the cycle after teller_req[t] is seen.
REQ-016 SHALL have FSM states IDLE, GRANT, GAP.
REQ-017 IDLE -> GRANT SHALL occur when pending != 0 and pcount != 0 at the same edge.
REQ-018 In GRANT (exactly one cycle) SHALL assert pop and grant to the winner, set busy[winner], load serving_ticket[winner] <= head, increment head, clear pending[winner].
REQ-019 GRANT -> GAP unconditionally; GAP SHALL last GAP_CYCLES cycles, then -> IDLE; GAP_CYCLES=0 SHALL go GRANT -> IDLE.
REQ-020 Winner SHALL be round-robin: search starts at teller after last granted; after reset start at teller one.
REQ-021 At most one grant and one pop per GRANT state; no pop ever when pcount == 0.
REQ-022 Head and tail ticket counters SHALL be TICKET_W bits, wrapping modulo 2^TICKET_W; tail increments on push, head on grant.
REQ-023 push SHALL be ignored (tail not incremented) when pcount == 7 and no pop in that cycle.
REQ-024 Simultaneous push and grant with pcount == 7 SHALL increment both head and tail.
REQ-025 push with pcount == 0 SHALL not enable a grant in that same cycle; earliest grant is the following edge once pcount reads nonzero.
REQ-026 teller_req for a teller already pending SHALL be absorbed (no double grant).
REQ-027 next_ticket SHALL equal head; active_tellers SHALL equal popcount(busy), registered.
REQ-028 Latency pending-with-nonempty-queue to pop SHALL be 1 cycle from IDLE.

Reset
REQ-029 rst low SHALL immediately force: state IDLE, pop 0, grant 0, busy 0, pending 0, serving_ticket all 0, head 0, tail 0, active_tellers 0, RR pointer to teller one.
REQ-030 Reset asserted mid-GRANT or mid-GAP SHALL abort with no pop pulse emitted after release.
REQ-031 First grant after reset release SHALL need a fresh teller_req.

Structure
REQ-032 FSM state encoding, NUM_TELLERS=3 and the default TICKET_W SHALL live in the shared bank package.
REQ-033 Round-robin winner selection SHALL be one sub-module, rr_arbiter3 (inputs pending, last-grant pointer; output one-hot winner).
REQ-034 Block SHALL sit between the FSM/QueueCounter and the ROM, driving Down and teller-activity inputs.

Verification
REQ-035 Reset, pcount=3, teller_req=001 -> next cycle pop=1, grant=001, serving_ticket[0]=0, busy=001, active_tellers=1.
REQ-036 pcount=0, teller_req=111, then push with pcount->1 -> exactly one grant to 001, pending stays 110, no further pop until pcount nonzero.
REQ-037 pcount=5, pending=111 after grant to teller one -> next grants 010 then 100, separated by GAP_CYCLES+1 cycles.
REQ-038 17 push/grant pairs with TICKET_W=4 -> head wraps 15->0, serving_ticket shows 0 after 15.
REQ-039 pcount=7, push and grant same cycle -> head and tail both increment; push alone at 7 -> tail unchanged.
REQ-040 rst low during GAP -> all outputs 0 immediately, no pop after release until new teller_req.
